// File: rtl/cpu_pkg.sv
// Shared mini-CPU definitions used by the execute-stage multiplier.
package cpu_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational ripple-carry adder with carry-out and signed overflow flags.
module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_flag,
    output logic             overflow_flag
);

    always_comb begin
        logic c;
        logic c_msb;
        c     = 1'b0;
        c_msb = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) c_msb = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_flag    = c;
        // Overflow when the carry into the sign bit differs from the carry out of it.
        overflow_flag = c ^ c_msb;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative 32x32->64 shift-add multiplier (unsigned/signed) with ready/valid on both sides.
module seq_multiplier
    import cpu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    mul_state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mcand;
    logic               neg;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    assign add_b = lo[0] ? mcand : '0;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_add (
        .a             (hi),
        .b             (add_b),
        .sum           (add_sum),
        .carry_flag    (add_carry),
        .overflow_flag ()
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(MUL_ITERS - 1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
            product_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= is_signed ? abs_val(op_a) : op_a;
                        lo    <= is_signed ? abs_val(op_b) : op_b;
                        hi    <= '0;
                        cnt   <= '0;
                        neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    end
                end
                RUN: begin
                    // Shift the adder carry-out in at the top so no product bit is lost.
                    {hi, lo} <= {add_carry, add_sum, lo[WIDTH-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                end
                FIXUP: begin
                    product_r <= neg ? (~{hi, lo} + (2*WIDTH)'(1)) : {hi, lo};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == FIXUP);
    assign product   = product_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed bench for seq_multiplier against an arithmetic reference.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Returns just after the accept edge with in_valid dropped and operands scrambled.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("issue_timeout", 64'(in_ready), 64'd1);
        op_a      = a;
        op_b      = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        is_signed = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ovalid_fall"}, 64'(out_valid), 64'd0);
        chk({tag, "_iready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp);
        int lat;
        issue(a, b, s);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_product"}, product, exp);
        drain(tag);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] held;
        int          lat;
        logic [31:0] corners [5];

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        full_op("u_basic", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        full_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        full_op("s_mixed", 32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
        full_op("s_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        full_op("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);

        // Backpressure: product held and new requests ignored while the consumer stalls.
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_done(lat);
        chk("bp_latency", 64'(lat), 64'd33);
        chk("bp_product", product, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
        held = product;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            op_a     = $urandom;
            op_b     = $urandom;
            @(posedge clk);
            #1;
            chk("bp_hold_product", product, held);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_iready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        drain("bp");
        chk("bp_no_accept", 64'(busy), 64'd0);

        // Reset in the middle of the iterations.
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_iready", 64'(in_ready), 64'd1);
        chk("midrst_ovalid", 64'(out_valid), 64'd0);
        chk("midrst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        full_op("after_rst", 32'd2, 32'd2, 1'b0, 64'd4);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rs = 1'($urandom);
            full_op("rand", ra, rb, rs, ref_mul(ra, rb, rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
